// File: rtl/sort_mem_arbiter_if.sv
// Bus bundle for the sort memory arbiter: host port, sorter port,
// shared read data, memory macro side and lock status.
interface sort_mem_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          h_req;
    logic          h_wr;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          h_gnt;
    logic          h_rvalid;

    logic          s_req;
    logic          s_wr;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_lock;
    logic          s_gnt;
    logic          s_rvalid;

    logic [DW-1:0] rdata;

    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    logic          locked;
    logic          lock_err;

    // Arbiter side
    modport slave (
        input  h_req, h_wr, h_addr, h_wdata,
        input  s_req, s_wr, s_addr, s_wdata, s_lock,
        input  mem_rdata,
        output h_gnt, h_rvalid, s_gnt, s_rvalid, rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata,
        output locked, lock_err
    );

    // Requesters plus memory macro side
    modport master (
        output h_req, h_wr, h_addr, h_wdata,
        output s_req, s_wr, s_addr, s_wdata, s_lock,
        output mem_rdata,
        input  h_gnt, h_rvalid, s_gnt, s_rvalid, rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        input  locked, lock_err
    );
endinterface

// File: rtl/sort_mem_arbiter.sv
// Shares the single-port sort memory between the host port and the sort
// engine. Round-robin per access; the sorter may lock the port for an
// atomic read/read/write/write swap, guarded by a lock watchdog.
module sort_mem_arbiter #(
    parameter int AW       = 4,
    parameter int DW       = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sort_mem_arbiter_if.slave    bus
);
    localparam int WDW = $clog2(MAX_LOCK + 1);

    typedef enum logic { FREE, LOCKED } state_t;
    typedef enum logic { PTR_HOST, PTR_SORT } ptr_t;

    state_t        state, state_n;
    ptr_t          ptr, ptr_n;
    logic [WDW-1:0] wd, wd_n;
    logic          err_q, err_n;
    logic          h_gnt, s_gnt;
    logic          h_pend, s_pend;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] wdata_mux;
    logic          wr_mux;

    // State, pointer, watchdog and read-return registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FREE;
            ptr     <= PTR_HOST;
            wd      <= '0;
            err_q   <= 1'b0;
            h_pend  <= 1'b0;
            s_pend  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            wd     <= wd_n;
            err_q  <= err_n;
            h_pend <= h_gnt && !bus.h_wr;
            s_pend <= s_gnt && !bus.s_wr;
            if (h_pend || s_pend)
                rdata_q <= bus.mem_rdata;
        end
    end

    // Grant decision, lock FSM next state and watchdog
    always_comb begin
        h_gnt   = 1'b0;
        s_gnt   = 1'b0;
        state_n = state;
        ptr_n   = ptr;
        wd_n    = wd;
        err_n   = err_q;
        if (rst_n) begin
            case (state)
                FREE: begin
                    wd_n = '0;
                    if (bus.h_req && (!bus.s_req || ptr == PTR_HOST))
                        h_gnt = 1'b1;
                    else if (bus.s_req)
                        s_gnt = 1'b1;
                    if (h_gnt) ptr_n = PTR_SORT;
                    if (s_gnt) ptr_n = PTR_HOST;
                    if (s_gnt && bus.s_lock) state_n = LOCKED;
                end
                LOCKED: begin
                    // Host is shut out; pointer stays put until release.
                    s_gnt = bus.s_req;
                    if (s_gnt) begin
                        wd_n = '0;
                        if (!bus.s_lock) begin
                            state_n = FREE;
                            ptr_n   = PTR_HOST;
                        end
                    end else if (!bus.s_lock) begin
                        state_n = FREE;
                        ptr_n   = PTR_HOST;
                        wd_n    = '0;
                    end else if (wd == WDW'(MAX_LOCK - 1)) begin
                        // This idle cycle is the MAX_LOCK-th: force release.
                        state_n = FREE;
                        ptr_n   = PTR_HOST;
                        wd_n    = '0;
                        err_n   = 1'b1;
                    end else begin
                        wd_n = wd + WDW'(1);
                    end
                end
                default: state_n = FREE;
            endcase
        end
    end

    // Memory command mux from the granted side; zeros when idle
    always_comb begin
        wr_mux    = 1'b0;
        addr_mux  = '0;
        wdata_mux = '0;
        if (h_gnt) begin
            wr_mux    = bus.h_wr;
            addr_mux  = bus.h_addr;
            wdata_mux = bus.h_wdata;
        end else if (s_gnt) begin
            wr_mux    = bus.s_wr;
            addr_mux  = bus.s_addr;
            wdata_mux = bus.s_wdata;
        end
    end

    assign bus.h_gnt     = h_gnt;
    assign bus.s_gnt     = s_gnt;
    assign bus.mem_en    = h_gnt | s_gnt;
    assign bus.mem_wr    = wr_mux;
    assign bus.mem_addr  = addr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.locked    = (state == LOCKED);
    assign bus.lock_err  = err_q;

    // Memory data arrives in the return cycle itself, so it is passed
    // through then and held in rdata_q afterwards. Reset kills any
    // in-flight return immediately.
    assign bus.h_rvalid = rst_n & h_pend;
    assign bus.s_rvalid = rst_n & s_pend;
    assign bus.rdata    = !rst_n ? '0 :
                          (h_pend || s_pend) ? bus.mem_rdata : rdata_q;
endmodule

// File: tb/tb_sort_mem_arbiter.sv
// Directed bench for sort_mem_arbiter with a read-return scoreboard.
module tb_sort_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sort_mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    sort_mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Memory macro model, 1-cycle read latency
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rd_q = '0;
    logic          loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
            mem[3] <= 8'h5A;
            loaded <= 1'b1;
        end else if (bus.mem_en) begin
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
            else            rd_q <= mem[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rd_q;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic          side;   // 0 host, 1 sorter
        logic [DW-1:0] data;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rvalid must match the head of the scoreboard
    always @(negedge clk) begin
        if (bus.h_rvalid || bus.s_rvalid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rvalid: got h=%0b s=%0b expected none at %0t",
                         bus.h_rvalid, bus.s_rvalid, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rv_side", {30'd0, bus.h_rvalid, bus.s_rvalid}, e.side ? 32'd1 : 32'd2);
                chk("rv_data", 32'(bus.rdata), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic host(input logic req, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.h_req = req; bus.h_wr = wr; bus.h_addr = a; bus.h_wdata = d;
    endtask

    task automatic sorter(input logic req, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic lk);
        bus.s_req = req; bus.s_wr = wr; bus.s_addr = a; bus.s_wdata = d; bus.s_lock = lk;
    endtask

    task automatic push(input logic side, input logic [DW-1:0] d);
        exp_t e;
        e.side = side;
        e.data = d;
        q.push_back(e);
    endtask

    initial begin
        // Reset with both requesters asking
        host(1, 0, 3, 0);
        sorter(1, 0, 3, 0, 0);
        tick(); tick();
        mid();
        chk("rst_gnt", {30'd0, bus.h_gnt, bus.s_gnt}, 0);
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_locked", {30'd0, bus.locked, bus.lock_err}, 0);
        chk("rst_rv", {30'd0, bus.h_rvalid, bus.s_rvalid}, 0);
        chk("rst_rdata", 32'(bus.rdata), 0);

        // Release with host read of addr 3
        tick();
        rst_n = 1'b1;
        sorter(0, 0, 0, 0, 0);
        mid();
        chk("h_first_gnt", {30'd0, bus.h_gnt, bus.s_gnt}, 2);
        chk("h_first_addr", {27'd0, bus.mem_en, bus.mem_addr}, 32'h13);
        push(0, 8'h5A);
        tick();
        host(0, 0, 0, 0);
        mid();

        // Fresh reset, then round-robin over 6 cycles
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        host(1, 0, 3, 0);
        sorter(1, 0, 3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            mid();
            chk("rr_gnt", {30'd0, bus.h_gnt, bus.s_gnt}, (i % 2 == 0) ? 32'd2 : 32'd1);
            push((i % 2) != 0, 8'h5A);
            tick();
        end
        host(0, 0, 0, 0);
        sorter(0, 0, 0, 0, 0);

        // Host-only write moves the pointer to the sorter
        host(1, 1, 2, 8'h11);
        mid();
        chk("hw2_gnt", 32'(bus.h_gnt), 1);
        tick();

        // Locked swap with host pressing
        host(1, 0, 2, 0);
        sorter(1, 0, 2, 0, 1);
        mid();
        chk("sw1", {29'd0, bus.h_gnt, bus.s_gnt, bus.locked}, 32'b010);
        push(1, 8'h11);
        tick();
        sorter(1, 0, 3, 0, 1);
        mid();
        chk("sw2", {29'd0, bus.h_gnt, bus.s_gnt, bus.locked}, 32'b011);
        push(1, 8'h5A);
        tick();
        sorter(1, 1, 2, 8'h5A, 1);
        mid();
        chk("sw3", {28'd0, bus.h_gnt, bus.s_gnt, bus.locked, bus.mem_wr}, 32'b0111);
        tick();
        sorter(1, 1, 3, 8'h11, 0);
        mid();
        chk("sw4", {29'd0, bus.h_gnt, bus.s_gnt, bus.locked}, 32'b011);
        chk("sw4_wdata", 32'(bus.mem_wdata), 32'h11);
        tick();
        sorter(0, 0, 0, 0, 0);
        mid();
        chk("sw_after", {29'd0, bus.h_gnt, bus.s_gnt, bus.locked}, 32'b100);
        push(0, 8'h5A);
        tick();

        // Watchdog: lock then go idle with s_lock held
        host(0, 0, 0, 0);
        sorter(1, 0, 3, 0, 1);
        mid();
        chk("wd_lock_gnt", 32'(bus.s_gnt), 1);
        push(1, 8'h11);
        tick();
        host(1, 0, 2, 0);
        sorter(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) begin
            mid();
            chk("wd_hold", {29'd0, bus.locked, bus.lock_err, bus.h_gnt}, 32'b100);
            tick();
        end
        mid();
        chk("wd_release", {29'd0, bus.locked, bus.lock_err, bus.h_gnt}, 32'b011);
        push(0, 8'h5A);
        tick();
        sorter(0, 0, 0, 0, 0);

        // Host writes 0xC3 to 15, sorter reads it back
        host(1, 1, 15, 8'hC3);
        mid();
        chk("wb_hw_gnt", 32'(bus.h_gnt), 1);
        tick();
        host(0, 0, 0, 0);
        sorter(1, 0, 15, 0, 0);
        mid();
        chk("wb_sr_gnt", 32'(bus.s_gnt), 1);
        push(1, 8'hC3);
        tick();
        sorter(0, 0, 0, 0, 0);
        mid();
        chk("err_sticky", 32'(bus.lock_err), 1);
        tick();
        mid();
        chk("rdata_hold", 32'(bus.rdata), 32'hC3);
        chk("idle_mem_en", 32'(bus.mem_en), 0);

        // Reset right after a granted read drops the return
        tick();
        host(1, 0, 15, 0);
        mid();
        chk("mr_gnt", 32'(bus.h_gnt), 1);
        tick();
        rst_n = 1'b0;
        host(0, 0, 0, 0);
        mid();
        chk("mr_rv", {30'd0, bus.h_rvalid, bus.s_rvalid}, 0);
        tick();
        mid();
        chk("mr_state", {30'd0, bus.locked, bus.lock_err}, 0);
        tick();
        rst_n = 1'b1;
        host(1, 0, 15, 0);
        sorter(1, 0, 15, 0, 0);
        mid();
        chk("mr_ptr_host", {30'd0, bus.h_gnt, bus.s_gnt}, 2);
        push(0, 8'hC3);
        tick();
        host(0, 0, 0, 0);
        mid();
        chk("mr_then_s", 32'(bus.s_gnt), 1);
        push(1, 8'hC3);
        tick();
        sorter(0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("sb_empty", 32'(q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
